// File: rtl/mux_sel_seq.sv
// Sequencer for the 16:1 mux: holds a word on di, scans the selects, and streams y out on a valid/ready port.
// Optional self-check of the reassembled word is enabled by defining MUX_SEL_CHECK_EN.
module mux_sel_seq #(
  parameter int MSB_FIRST = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] load_data,
  output logic [15:0] di,
  output logic        s0,
  output logic        s1,
  output logic        s2,
  output logic        s3,
  input  logic        y,
  output logic        sout,
  output logic        sout_valid,
  input  logic        sout_ready,
  output logic        sout_last,
  output logic        err
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [3:0] CNT_START = (MSB_FIRST != 0) ? 4'd15 : 4'd0;

  state_t      state_q, state_d;
  logic [15:0] di_q, di_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  nbit_q, nbit_d;
  logic        sout_q, sout_d;
  logic        sout_valid_q, sout_valid_d;
  logic        sout_last_q, sout_last_d;
  logic        accept, sample, final_sample;

  always_comb begin
    state_d      = state_q;
    di_d         = di_q;
    cnt_d        = cnt_q;
    nbit_d       = nbit_q;
    sout_d       = sout_q;
    sout_valid_d = sout_valid_q;
    sout_last_d  = sout_last_q;

    load_ready   = (state_q == IDLE);
    accept       = (state_q == IDLE) && load_valid;
    // A new bit may only enter the output register once the old one has gone.
    sample       = (state_q == SCAN) && (!sout_valid_q || sout_ready);
    final_sample = sample && (nbit_q == 4'd15);

    if (accept) begin
      di_d    = load_data;
      cnt_d   = CNT_START;
      nbit_d  = 4'd0;
      state_d = SCAN;
    end

    if (sample) begin
      sout_d       = y;
      sout_valid_d = 1'b1;
      sout_last_d  = final_sample;
      nbit_d       = nbit_q + 4'd1;
      // The counter is left on the last index so it never wraps.
      if (final_sample) begin
        state_d = IDLE;
      end else if (MSB_FIRST != 0) begin
        cnt_d = cnt_q - 4'd1;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end else if (sout_ready) begin
      sout_valid_d = 1'b0;
      sout_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      di_q         <= '0;
      cnt_q        <= '0;
      nbit_q       <= '0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      sout_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      di_q         <= di_d;
      cnt_q        <= cnt_d;
      nbit_q       <= nbit_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      sout_last_q  <= sout_last_d;
    end
  end

`ifdef MUX_SEL_CHECK_EN
  logic [15:0] shadow_q, shadow_d;
  logic        err_q, err_d;

  // Shadow is written at the scan index so it lines up bit-for-bit with di.
  always_comb begin
    shadow_d = shadow_q;
    err_d    = 1'b0;
    if (accept) begin
      shadow_d = '0;
    end
    if (sample) begin
      shadow_d[cnt_q] = y;
    end
    if (final_sample) begin
      err_d = (shadow_d != di_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
      err_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      err_q    <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Scan index i maps to {s2,s3,s0,s1} because s0/s2 are the MSBs of each mux level.
  assign {s2, s3, s0, s1} = cnt_q;
  assign di         = di_q;
  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign sout_last  = sout_last_q;

endmodule

// File: tb/tb_mux_sel_seq.sv
// Bench for mux_sel_seq: LSB-first and MSB-first instances share stimulus, each driving its own mux model.
// Define MUX_SEL_CHECK_EN to also exercise the self-check error path.
module tb_mux_sel_seq;

`ifdef MUX_SEL_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_valid = 1'b0;
  logic [15:0] load_data = 16'h0000;
  logic        sout_ready = 1'b1;
  logic        fault_en = 1'b0;

  logic [1:0]  load_ready_w, s0_w, s1_w, s2_w, s3_w, y_w;
  logic [1:0]  sout_w, sout_valid_w, sout_last_w, err_w;
  logic [15:0] di_w [2];
  logic [3:0]  sel_w [2];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int e0 = 0;

  // Behavioural model state per instance (index 1 is the MSB-first one).
  bit          m_busy  [2] = '{0, 0};
  logic [15:0] m_word  [2] = '{16'h0, 16'h0};
  logic [15:0] m_shadow[2] = '{16'h0, 16'h0};
  int          m_n     [2] = '{0, 0};
  bit          m_valid [2] = '{0, 0};
  bit          m_bit   [2] = '{0, 0};
  bit          m_last  [2] = '{0, 0};
  bit          m_err   [2] = '{0, 0};

  logic [63:0] cap      [2];
  int          capn     [2];
  int          errn     [2];
  int          last_cyc [2];

  always #5 clk = ~clk;

  mux_sel_seq #(.MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_ready(load_ready_w[0]), .load_data(load_data),
    .di(di_w[0]), .s0(s0_w[0]), .s1(s1_w[0]), .s2(s2_w[0]), .s3(s3_w[0]), .y(y_w[0]),
    .sout(sout_w[0]), .sout_valid(sout_valid_w[0]), .sout_ready(sout_ready),
    .sout_last(sout_last_w[0]), .err(err_w[0])
  );

  mux_sel_seq #(.MSB_FIRST(1)) dut_msb (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_ready(load_ready_w[1]), .load_data(load_data),
    .di(di_w[1]), .s0(s0_w[1]), .s1(s1_w[1]), .s2(s2_w[1]), .s3(s3_w[1]), .y(y_w[1]),
    .sout(sout_w[1]), .sout_valid(sout_valid_w[1]), .sout_ready(sout_ready),
    .sout_last(sout_last_w[1]), .err(err_w[1])
  );

  // The external 16:1 mux, with an optional stuck-at-0 at index 4.
  for (genvar k = 0; k < 2; k++) begin : g_mux
    assign sel_w[k] = {s2_w[k], s3_w[k], s0_w[k], s1_w[k]};
    assign y_w[k]   = (fault_en && sel_w[k] == 4'd4) ? 1'b0 : di_w[k][sel_w[k]];
  end

  function automatic int idx_of(input int k, input int n);
    return (k == 1) ? 15 - n : n;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic lv, input logic [15:0] data, input logic rdy);
    @(posedge clk);
    #2;
    load_valid = lv;
    load_data  = data;
    sout_ready = rdy;
  endtask

  task automatic clearCapture();
    for (int k = 0; k < 2; k++) begin
      cap[k] = '0;
      capn[k] = 0;
      errn[k] = 0;
      last_cyc[k] = -1;
    end
  endtask

  task automatic waitIdle();
    int t;
    t = 0;
    while (!(load_ready_w == 2'b11 && sout_valid_w == 2'b00) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      n_checks++;
      n_errors++;
      $display("[TB] FAIL wait_idle: timed out after %0d cycles, required idle", t);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic checkResetValues(input string tag);
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("%s u%0d load_ready", tag, k), load_ready_w[k], 1);
      checkOutput($sformatf("%s u%0d di", tag, k), di_w[k], 0);
      checkOutput($sformatf("%s u%0d sel", tag, k), sel_w[k], 0);
      checkOutput($sformatf("%s u%0d sout", tag, k), sout_w[k], 0);
      checkOutput($sformatf("%s u%0d sout_valid", tag, k), sout_valid_w[k], 0);
      checkOutput($sformatf("%s u%0d sout_last", tag, k), sout_last_w[k], 0);
      checkOutput($sformatf("%s u%0d err", tag, k), err_w[k], 0);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Model: a word is 16 bits taken in scan order, one per free slot in the output register.
  initial forever begin
    @(posedge clk or posedge rst);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_busy[k] = 0; m_word[k] = '0; m_shadow[k] = '0; m_n[k] = 0;
        m_valid[k] = 0; m_bit[k] = 0; m_last[k] = 0; m_err[k] = 0;
      end else begin
        bit smp, acc, b;
        int ix;
        smp = m_busy[k] && (!m_valid[k] || sout_ready);
        acc = !m_busy[k] && load_valid;
        m_err[k] = 0;
        if (smp) begin
          ix = idx_of(k, m_n[k]);
          b = (fault_en && ix == 4) ? 1'b0 : m_word[k][ix];
          m_bit[k] = b;
          m_valid[k] = 1;
          m_last[k] = (m_n[k] == 15);
          m_shadow[k][ix] = b;
          if (m_n[k] == 15) begin
            m_busy[k] = 0;
            m_err[k] = CHECK_EN && (m_shadow[k] != m_word[k]);
          end
          m_n[k]++;
        end else if (sout_ready) begin
          m_valid[k] = 0;
          m_last[k] = 0;
        end
        if (acc) begin
          m_word[k] = load_data;
          m_busy[k] = 1;
          m_n[k] = 0;
          m_shadow[k] = '0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, plus capture of the delivered stream.
  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("u%0d load_ready", k), load_ready_w[k], !m_busy[k]);
      checkOutput($sformatf("u%0d di", k), di_w[k], m_word[k]);
      checkOutput($sformatf("u%0d sout_valid", k), sout_valid_w[k], m_valid[k]);
      checkOutput($sformatf("u%0d err", k), err_w[k], m_err[k]);
      if (m_valid[k]) begin
        checkOutput($sformatf("u%0d sout", k), sout_w[k], m_bit[k]);
        checkOutput($sformatf("u%0d sout_last", k), sout_last_w[k], m_last[k]);
      end
      if (m_busy[k]) begin
        checkOutput($sformatf("u%0d sel", k), sel_w[k], idx_of(k, m_n[k]));
      end
      if (sout_valid_w[k] && sout_ready) begin
        cap[k] = {cap[k][62:0], sout_w[k]};
        capn[k]++;
      end
      if (sout_valid_w[k] && sout_last_w[k]) last_cyc[k] = cyc;
      if (err_w[k]) errn[k]++;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t;
    clearCapture();
    repeat (3) @(posedge clk);
    #2;
    checkResetValues("reset");
    rst = 1'b0;

    // Plain word, both scan orders.
    $display("[TB] word 0xA5C3, no backpressure");
    clearCapture();
    applyStimulus(1, 16'hA5C3, 1);
    applyStimulus(0, 16'h0000, 1);
    e0 = cyc;
    @(negedge clk);
    checkOutput("first sel lsb", sel_w[0], 4'h0);
    checkOutput("first sel msb", sel_w[1], 4'hF);
    t = 0;
    while (!load_ready_w[0] && t < 40) begin
      @(negedge clk);
      t++;
    end
    checkOutput("load_ready return", cyc - e0, 16);
    waitIdle();
    checkOutput("stream lsb", cap[0][15:0], 16'hC3A5);
    checkOutput("stream msb", cap[1][15:0], 16'hA5C3);
    checkOutput("count lsb", capn[0], 16);
    checkOutput("last at E16", last_cyc[0] - e0, 16);

    // Five stalled edges (E3..E7).
    $display("[TB] word 0xA5C3, backpressure");
    clearCapture();
    applyStimulus(1, 16'hA5C3, 1);
    applyStimulus(0, 16'h0000, 1);
    e0 = cyc;
    applyStimulus(0, 16'h0000, 1);
    applyStimulus(0, 16'h0000, 0);
    repeat (4) applyStimulus(0, 16'h0000, 0);
    applyStimulus(0, 16'h0000, 1);
    waitIdle();
    checkOutput("stall stream lsb", cap[0][15:0], 16'hC3A5);
    checkOutput("stall stream msb", cap[1][15:0], 16'hA5C3);
    checkOutput("stall last at E21", last_cyc[0] - e0, 21);

    // Back-to-back words with load_data churning during the scan.
    $display("[TB] back-to-back 0xFFFF then 0x0001");
    clearCapture();
    applyStimulus(1, 16'hFFFF, 1);
    applyStimulus(1, 16'h1357, 1);
    e0 = cyc;
    repeat (9) applyStimulus(1, 16'h1357, 1);
    applyStimulus(1, 16'h0001, 1);
    repeat (7) applyStimulus(1, 16'h0001, 1);
    applyStimulus(0, 16'h0000, 1);
    waitIdle();
    checkOutput("b2b stream lsb", cap[0][31:0], 32'hFFFF8000);
    checkOutput("b2b stream msb", cap[1][31:0], 32'hFFFF0001);
    checkOutput("b2b count", capn[1], 32);
    checkOutput("b2b last at E33", last_cyc[1] - e0, 33);

    // Reset in the middle of a word.
    $display("[TB] reset during 0x1234");
    clearCapture();
    applyStimulus(1, 16'h1234, 1);
    applyStimulus(0, 16'h0000, 1);
    repeat (7) applyStimulus(0, 16'h0000, 1);
    rst = 1'b1;
    #1;
    checkResetValues("midreset");
    @(posedge clk);
    #2;
    rst = 1'b0;
    clearCapture();
    applyStimulus(1, 16'h00FF, 1);
    applyStimulus(0, 16'h0000, 1);
    waitIdle();
    checkOutput("after reset lsb", cap[0][15:0], 16'hFF00);
    checkOutput("after reset msb", cap[1][15:0], 16'h00FF);
    checkOutput("after reset count", capn[0], 16);

    // Healthy mux: no error pulse.
    clearCapture();
    applyStimulus(1, 16'h0010, 1);
    applyStimulus(0, 16'h0000, 1);
    waitIdle();
    checkOutput("good mux err count lsb", errn[0], 0);
    checkOutput("good mux err count msb", errn[1], 0);
    checkOutput("good mux stream lsb", cap[0][15:0], 16'h0800);

`ifdef MUX_SEL_CHECK_EN
    // Stuck-at-0 at index 4 corrupts bit 4 of 0x0010.
    $display("[TB] faulty mux with self-check");
    clearCapture();
    fault_en = 1'b1;
    applyStimulus(1, 16'h0010, 1);
    applyStimulus(0, 16'h0000, 1);
    waitIdle();
    fault_en = 1'b0;
    checkOutput("fault err count lsb", errn[0], 1);
    checkOutput("fault err count msb", errn[1], 1);
    checkOutput("fault stream lsb", cap[0][15:0], 16'h0000);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
